// File: rtl/ir_encoder_pkg.sv
// Shared definitions for the instruction encoder: IRN codes (same numbering
// as the decode stage), MIPS opcode/func constants, field bit ranges and
// small packing helpers.
package ir_encoder_pkg;

  localparam int irn_size = 6;

  // Code 0 and codes above IRN_MFC0 are undefined and get rejected.
  typedef enum logic [irn_size-1:0] {
    IRN_NONE  = 6'd0,
    IRN_ADD   = 6'd1,  IRN_ADDU  = 6'd2,  IRN_SUB   = 6'd3,  IRN_SUBU  = 6'd4,
    IRN_AND   = 6'd5,  IRN_OR    = 6'd6,  IRN_XOR   = 6'd7,  IRN_NOR   = 6'd8,
    IRN_SLT   = 6'd9,  IRN_SLTU  = 6'd10, IRN_SLLV  = 6'd11, IRN_SRLV  = 6'd12,
    IRN_SRAV  = 6'd13, IRN_SLL   = 6'd14, IRN_SRL   = 6'd15, IRN_SRA   = 6'd16,
    IRN_MULT  = 6'd17, IRN_MULTU = 6'd18, IRN_DIV   = 6'd19, IRN_DIVU  = 6'd20,
    IRN_MTHI  = 6'd21, IRN_MTLO  = 6'd22, IRN_MFHI  = 6'd23, IRN_MFLO  = 6'd24,
    IRN_JR    = 6'd25, IRN_JALR  = 6'd26, IRN_ADDI  = 6'd27, IRN_ADDIU = 6'd28,
    IRN_ANDI  = 6'd29, IRN_ORI   = 6'd30, IRN_XORI  = 6'd31, IRN_LUI   = 6'd32,
    IRN_SLTI  = 6'd33, IRN_SLTIU = 6'd34, IRN_LB    = 6'd35, IRN_LBU   = 6'd36,
    IRN_LH    = 6'd37, IRN_LHU   = 6'd38, IRN_LW    = 6'd39, IRN_SB    = 6'd40,
    IRN_SH    = 6'd41, IRN_SW    = 6'd42, IRN_BEQ   = 6'd43, IRN_BNE   = 6'd44,
    IRN_BLEZ  = 6'd45, IRN_BGTZ  = 6'd46, IRN_BLTZ  = 6'd47, IRN_BGEZ  = 6'd48,
    IRN_J     = 6'd49, IRN_JAL   = 6'd50, IRN_ERET  = 6'd51, IRN_MTC0  = 6'd52,
    IRN_MFC0  = 6'd53
  } irn_e;

  // Field bit ranges
  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FN_HI = 5,  FN_LO = 0;

  // Opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02,
                         OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e,
                         OP_LUI = 6'h0f, OP_COP0 = 6'h10, OP_LB = 6'h20,
                         OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

  // Func codes for op 0
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_JR = 6'h08, FN_JALR = 6'h09, FN_MFHI = 6'h10,
                         FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13,
                         FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1a,
                         FN_DIVU = 6'h1b, FN_ADD = 6'h20, FN_ADDU = 6'h21,
                         FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
                         FN_SLT = 6'h2a, FN_SLTU = 6'h2b;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  // R-type word with op 0; caller passes zeros for unused fields.
  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    logic [31:0] w;
    w = '0;
    w[OP_HI:OP_LO] = OP_SPECIAL;
    w[RS_HI:RS_LO] = rs;
    w[RT_HI:RT_LO] = rt;
    w[RD_HI:RD_LO] = rd;
    w[SH_HI:SH_LO] = sh;
    w[FN_HI:FN_LO] = fn;
    return w;
  endfunction

  // I-type word.
  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_HI:OP_LO] = op;
    w[RS_HI:RS_LO] = rs;
    w[RT_HI:RT_LO] = rt;
    w[15:0]        = imm;
    return w;
  endfunction

endpackage

// File: rtl/ir_encoder_if.sv
// Request/response bundle of the instruction encoder.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and its payload until that edge; ready never
// depends combinationally on valid. The same rule applies to both sides.
interface ir_encoder_if;
  import ir_encoder_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [irn_size-1:0] in_irn;
  logic [4:0]          in_rs;
  logic [4:0]          in_rt;
  logic [4:0]          in_rd;
  logic [4:0]          in_shamt;
  logic [25:0]         in_imm;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_word;

  modport master (
    output in_valid, in_irn, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_irn, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    output in_ready, out_valid, out_word
  );

endinterface

// File: rtl/ir_field_pack.sv
// Combinational packer: IRN plus raw fields in, 32-bit MIPS word out.
// Fields an instruction does not use are forced to zero.
module ir_field_pack
  import ir_encoder_pkg::*;
(
  input  logic [irn_size-1:0] irn,
  input  logic [4:0]          rs,
  input  logic [4:0]          rt,
  input  logic [4:0]          rd,
  input  logic [4:0]          shamt,
  input  logic [25:0]         imm,
  output logic [31:0]         word,
  output logic                valid_irn
);

  logic [15:0] imm16;
  assign imm16 = imm[15:0];

  // Select the packing form for each IRN; undefined codes flag invalid.
  always_comb begin
    word      = '0;
    valid_irn = 1'b1;
    case (irn)
      IRN_ADD:   word = pack_r(rs, rt, rd, 5'd0, FN_ADD);
      IRN_ADDU:  word = pack_r(rs, rt, rd, 5'd0, FN_ADDU);
      IRN_SUB:   word = pack_r(rs, rt, rd, 5'd0, FN_SUB);
      IRN_SUBU:  word = pack_r(rs, rt, rd, 5'd0, FN_SUBU);
      IRN_AND:   word = pack_r(rs, rt, rd, 5'd0, FN_AND);
      IRN_OR:    word = pack_r(rs, rt, rd, 5'd0, FN_OR);
      IRN_XOR:   word = pack_r(rs, rt, rd, 5'd0, FN_XOR);
      IRN_NOR:   word = pack_r(rs, rt, rd, 5'd0, FN_NOR);
      IRN_SLT:   word = pack_r(rs, rt, rd, 5'd0, FN_SLT);
      IRN_SLTU:  word = pack_r(rs, rt, rd, 5'd0, FN_SLTU);
      IRN_SLLV:  word = pack_r(rs, rt, rd, 5'd0, FN_SLLV);
      IRN_SRLV:  word = pack_r(rs, rt, rd, 5'd0, FN_SRLV);
      IRN_SRAV:  word = pack_r(rs, rt, rd, 5'd0, FN_SRAV);
      IRN_SLL:   word = pack_r(5'd0, rt, rd, shamt, FN_SLL);
      IRN_SRL:   word = pack_r(5'd0, rt, rd, shamt, FN_SRL);
      IRN_SRA:   word = pack_r(5'd0, rt, rd, shamt, FN_SRA);
      IRN_MULT:  word = pack_r(rs, rt, 5'd0, 5'd0, FN_MULT);
      IRN_MULTU: word = pack_r(rs, rt, 5'd0, 5'd0, FN_MULTU);
      IRN_DIV:   word = pack_r(rs, rt, 5'd0, 5'd0, FN_DIV);
      IRN_DIVU:  word = pack_r(rs, rt, 5'd0, 5'd0, FN_DIVU);
      IRN_MTHI:  word = pack_r(rs, 5'd0, 5'd0, 5'd0, FN_MTHI);
      IRN_MTLO:  word = pack_r(rs, 5'd0, 5'd0, 5'd0, FN_MTLO);
      IRN_MFHI:  word = pack_r(5'd0, 5'd0, rd, 5'd0, FN_MFHI);
      IRN_MFLO:  word = pack_r(5'd0, 5'd0, rd, 5'd0, FN_MFLO);
      IRN_JR:    word = pack_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      IRN_JALR:  word = pack_r(rs, 5'd0, rd, 5'd0, FN_JALR);
      IRN_ADDI:  word = pack_i(OP_ADDI, rs, rt, imm16);
      IRN_ADDIU: word = pack_i(OP_ADDIU, rs, rt, imm16);
      IRN_ANDI:  word = pack_i(OP_ANDI, rs, rt, imm16);
      IRN_ORI:   word = pack_i(OP_ORI, rs, rt, imm16);
      IRN_XORI:  word = pack_i(OP_XORI, rs, rt, imm16);
      IRN_LUI:   word = pack_i(OP_LUI, 5'd0, rt, imm16);
      IRN_SLTI:  word = pack_i(OP_SLTI, rs, rt, imm16);
      IRN_SLTIU: word = pack_i(OP_SLTIU, rs, rt, imm16);
      IRN_LB:    word = pack_i(OP_LB, rs, rt, imm16);
      IRN_LBU:   word = pack_i(OP_LBU, rs, rt, imm16);
      IRN_LH:    word = pack_i(OP_LH, rs, rt, imm16);
      IRN_LHU:   word = pack_i(OP_LHU, rs, rt, imm16);
      IRN_LW:    word = pack_i(OP_LW, rs, rt, imm16);
      IRN_SB:    word = pack_i(OP_SB, rs, rt, imm16);
      IRN_SH:    word = pack_i(OP_SH, rs, rt, imm16);
      IRN_SW:    word = pack_i(OP_SW, rs, rt, imm16);
      IRN_BEQ:   word = pack_i(OP_BEQ, rs, rt, imm16);
      IRN_BNE:   word = pack_i(OP_BNE, rs, rt, imm16);
      IRN_BLEZ:  word = pack_i(OP_BLEZ, rs, 5'd0, imm16);
      IRN_BGTZ:  word = pack_i(OP_BGTZ, rs, 5'd0, imm16);
      IRN_BLTZ:  word = pack_i(OP_REGIMM, rs, 5'd0, imm16);
      IRN_BGEZ:  word = pack_i(OP_REGIMM, rs, 5'd1, imm16);
      IRN_J:     word = {OP_J, imm};
      IRN_JAL:   word = {OP_JAL, imm};
      IRN_ERET:  word = ERET_WORD;
      IRN_MTC0:  word = {OP_COP0, 5'd4, rt, rd, 11'd0};
      IRN_MFC0:  word = {OP_COP0, 5'd0, rt, rd, 11'd0};
      default:   valid_irn = 1'b0;
    endcase
  end

endmodule

// File: rtl/ir_encoder.sv
// Instruction encoder top: packs accepted requests and queues the words in
// a DEPTH-entry FIFO. Requests with an undefined IRN are consumed, dropped
// and counted.
module ir_encoder
  import ir_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  ir_encoder_if.slave      bus,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   last_word;
  logic [31:0]   enc_word;
  logic          enc_valid;
  logic          accept;
  logic          push;
  logic          pop;

  ir_field_pack u_pack (
    .irn       (bus.in_irn),
    .rs        (bus.in_rs),
    .rt        (bus.in_rt),
    .rd        (bus.in_rd),
    .shamt     (bus.in_shamt),
    .imm       (bus.in_imm),
    .word      (enc_word),
    .valid_irn (enc_valid)
  );

  // Flags come from the count register only, so there is no path from
  // in_valid or out_ready; a full FIFO refuses input even while draining.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && enc_valid;
  assign pop           = bus.out_valid && bus.out_ready;

  // When empty, show the last word that left (0 after reset) rather than a
  // stale slot the read pointer happens to sit on.
  assign bus.out_word = bus.out_valid ? mem[rd_ptr] : last_word;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  // Pointers, occupancy and the last-popped word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last_word <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Rejected-IRN pulse and saturating counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= accept && !enc_valid;
      if (accept && !enc_valid && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_ir_encoder.sv
// Directed bench for ir_encoder: hand-computed encodings, FIFO fill/drain
// ordering, rejected IRNs, error-counter saturation and asynchronous reset.
module tb_ir_encoder;
  import ir_encoder_pkg::*;

  localparam int DEPTH = 4;
  localparam int ERR_W = 8;
  localparam int NV    = 16;

  typedef struct {
    logic [irn_size-1:0] irn;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [4:0]          sh;
    logic [25:0]         imm;
    logic [31:0]         word;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  ir_encoder_if bus ();

  ir_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err     (err),
    .err_cnt (err_cnt)
  );

  vec_t        vecs [NV];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_vec(input int i);
    bus.in_irn   = vecs[i].irn;
    bus.in_rs    = vecs[i].rs;
    bus.in_rt    = vecs[i].rt;
    bus.in_rd    = vecs[i].rd;
    bus.in_shamt = vecs[i].sh;
    bus.in_imm   = vecs[i].imm;
  endtask

  task automatic drive_bad(input logic [irn_size-1:0] code);
    bus.in_irn   = code;
    bus.in_rs    = 5'd1;
    bus.in_rt    = 5'd2;
    bus.in_rd    = 5'd3;
    bus.in_shamt = 5'd0;
    bus.in_imm   = 26'd0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // stimulus and checks
  initial begin
    int nxt;
    //              irn        rs     rt     rd     sh     imm            word
    vecs[0]  = '{IRN_ADDU,  5'd1,  5'd2,  5'd3,  5'd0,  26'h0000000, 32'h00221821};
    vecs[1]  = '{IRN_ORI,   5'd0,  5'd5,  5'd0,  5'd0,  26'h0001234, 32'h34051234};
    vecs[2]  = '{IRN_BGEZ,  5'd4,  5'd0,  5'd0,  5'd0,  26'h000FFFE, 32'h0481FFFE};
    vecs[3]  = '{IRN_JAL,   5'd1,  5'd0,  5'd0,  5'd0,  26'h0100040, 32'h0C100040};
    vecs[4]  = '{IRN_MTC0,  5'd0,  5'd2,  5'd12, 5'd0,  26'h0000000, 32'h40826000};
    vecs[5]  = '{IRN_SLL,   5'd9,  5'd7,  5'd8,  5'd3,  26'h0000000, 32'h000740C0};
    vecs[6]  = '{IRN_LUI,   5'd3,  5'd1,  5'd0,  5'd0,  26'h000ABCD, 32'h3C01ABCD};
    vecs[7]  = '{IRN_LW,    5'd29, 5'd8,  5'd0,  5'd0,  26'h2A50010, 32'h8FA80010};
    vecs[8]  = '{IRN_ERET,  5'd31, 5'd31, 5'd31, 5'd31, 26'h3FFFFFF, 32'h42000018};
    vecs[9]  = '{IRN_JR,    5'd31, 5'd0,  5'd0,  5'd0,  26'h0000000, 32'h03E00008};
    vecs[10] = '{IRN_MFLO,  5'd5,  5'd6,  5'd4,  5'd0,  26'h0000000, 32'h00002012};
    vecs[11] = '{IRN_SW,    5'd29, 5'd31, 5'd0,  5'd0,  26'h000FFFC, 32'hAFBFFFFC};
    vecs[12] = '{IRN_BLEZ,  5'd2,  5'd7,  5'd0,  5'd0,  26'h0000003, 32'h18400003};
    vecs[13] = '{IRN_MFC0,  5'd0,  5'd3,  5'd14, 5'd0,  26'h0000000, 32'h40037000};
    vecs[14] = '{IRN_JALR,  5'd6,  5'd0,  5'd31, 5'd0,  26'h0000000, 32'h00C0F809};
    vecs[15] = '{IRN_MULT,  5'd4,  5'd5,  5'd6,  5'd0,  26'h0000000, 32'h00850018};

    // reset
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_bad('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_word", bus.out_word, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);

    // single encodings: visible one edge after accept, held after pop
    for (int i = 0; i < NV; i++) begin
      drive_vec(i);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check($sformatf("single_valid_%0d", i), bus.out_valid, 1);
      check($sformatf("single_word_%0d", i), bus.out_word, vecs[i].word);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check($sformatf("single_empty_%0d", i), bus.out_valid, 0);
      check($sformatf("single_hold_%0d", i), bus.out_word, vecs[i].word);
    end
    check("no_err_for_valid", err_cnt, 0);

    // fill to DEPTH with the consumer stalled
    for (int i = 0; i < DEPTH; i++) begin
      drive_vec(i);
      bus.in_valid = 1'b1;
      step();
      exp_q.push_back(vecs[i].word);
      check($sformatf("fill_in_ready_%0d", i), bus.in_ready, (i < DEPTH - 1) ? 1 : 0);
    end
    bus.in_valid = 1'b0;
    check("full_head", bus.out_word, exp_q[0]);
    step();
    check("full_head_stable", bus.out_word, exp_q[0]);
    check("full_in_ready", bus.in_ready, 0);

    // drain with in_valid held: refill only once not full, order preserved
    nxt = DEPTH;
    for (int c = 0; c < 20; c++) begin
      bit acc;
      bit pp;
      bus.in_valid  = (nxt < 10);
      if (nxt < 10) drive_vec(nxt);
      bus.out_ready = 1'b1;
      check("stream_in_ready", bus.in_ready, (exp_q.size() != DEPTH) ? 1 : 0);
      check("stream_out_valid", bus.out_valid, (exp_q.size() != 0) ? 1 : 0);
      if (exp_q.size() != 0) check("stream_word", bus.out_word, exp_q[0]);
      acc = bus.in_valid && (exp_q.size() != DEPTH);
      pp  = (exp_q.size() != 0);
      @(posedge clk);
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(vecs[nxt].word);
        nxt++;
      end
      @(negedge clk);
      if (nxt >= 10 && exp_q.size() == 0) break;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_all_sent", nxt, 10);
    check("stream_drained", bus.out_valid, 0);
    check("stream_last_word", bus.out_word, vecs[9].word);

    // unknown IRN 0: consumed, err pulse, nothing queued
    drive_bad('0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("bad0_err", err, 1);
    check("bad0_err_cnt", err_cnt, 1);
    check("bad0_out_valid", bus.out_valid, 0);
    step();
    check("bad0_err_clear", err, 0);
    check("bad0_err_cnt_hold", err_cnt, 1);

    // rejected IRN at DEPTH-1 must not fill the FIFO
    for (int i = 10; i < 13; i++) begin
      drive_vec(i);
      bus.in_valid = 1'b1;
      step();
    end
    drive_bad(6'd63);
    step();
    bus.in_valid = 1'b0;
    check("bad63_err", err, 1);
    check("bad63_err_cnt", err_cnt, 2);
    check("bad63_in_ready", bus.in_ready, 1);
    drive_vec(13);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("fullm1_now_full", bus.in_ready, 0);
    check("fullm1_head", bus.out_word, vecs[10].word);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("three_left_head", bus.out_word, vecs[11].word);
    check("three_left_in_ready", bus.in_ready, 1);

    // asynchronous reset with 3 words queued
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_word", bus.out_word, 0);
    check("arst_err_cnt", err_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("arst_no_err", err, 0);
    check("arst_still_empty", bus.out_valid, 0);

    // saturate the error counter
    drive_bad(6'd60);
    bus.in_valid = 1'b1;
    repeat (255) @(posedge clk);
    @(negedge clk);
    check("sat_reach", err_cnt, 255);
    check("sat_err_pulse", err, 1);
    step();
    bus.in_valid = 1'b0;
    check("sat_hold", err_cnt, 255);
    check("sat_out_valid", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
